// File: rtl/uart_tx_feeder.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_feeder
// Purpose  : Transmit-side word buffer feeding a UART transmitter. Host words
//            are queued in a small circular FIFO. Each word is issued on
//            DataIn with a one-cycle NewData strobe. The next word is not
//            issued until DoneTx has acknowledged the current one, or the
//            per-frame watchdog has expired.
// Ports    : CLK_Baudin  - baud clock, rising edge
//            Rst         - synchronous active-high reset
//            WrData/WrEn - host enqueue interface
//            Full/Empty/Count - FIFO status (registered)
//            DataIn/NewData   - transmitter word and start strobe
//            DoneTx      - transmitter frame-complete
//            Busy        - a frame is being issued or completed
//            Overflow/TimeoutErr - sticky error flags, cleared only by Rst
//            SentCount   - frames acknowledged by DoneTx (wraps)
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_feeder #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 8,
    parameter int ADDR_W     = 3,
    parameter int TIMEOUT    = 64
) (
    input  logic                  CLK_Baudin,
    input  logic                  Rst,
    input  logic [DATA_WIDTH-1:0] WrData,
    input  logic                  WrEn,
    output logic                  Full,
    output logic                  Empty,
    output logic [ADDR_W:0]       Count,
    output logic [DATA_WIDTH-1:0] DataIn,
    output logic                  NewData,
    input  logic                  DoneTx,
    output logic                  Busy,
    output logic                  Overflow,
    output logic                  TimeoutErr,
    output logic [15:0]           SentCount
);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_LOAD = 2'd1;
    localparam logic [1:0] c_ST_WAIT = 2'd2;
    localparam logic [1:0] c_ST_GAP  = 2'd3;

    // One extra bit so TIMEOUT-1 always fits, whatever TIMEOUT is.
    localparam int               c_TMR_W     = $clog2(TIMEOUT + 1);
    localparam logic [c_TMR_W-1:0] c_TMR_LAST = c_TMR_W'(TIMEOUT - 1);
    localparam logic [ADDR_W:0]  c_DEPTH_CNT = (ADDR_W + 1)'(DEPTH);

    logic [1:0]            r_state;
    logic [1:0]            w_state_nxt;

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [ADDR_W-1:0]     r_wr_ptr;
    logic [ADDR_W-1:0]     r_rd_ptr;
    logic [ADDR_W:0]       r_count;
    logic [ADDR_W:0]       w_count_nxt;
    logic                  r_full;
    logic                  r_empty;

    logic [DATA_WIDTH-1:0] r_data_in;
    logic [c_TMR_W-1:0]    r_timer;
    logic                  r_overflow;
    logic                  r_timeout_err;
    logic [15:0]           r_sent_count;

    logic                  w_push;
    logic                  w_drop;
    logic                  w_pop;
    logic                  w_done;
    logic                  w_expire;

    // Full is the registered flag, so a write in a cycle that also pops
    // is still dropped when the FIFO was full before the edge.
    assign w_push   = WrEn & ~r_full;
    assign w_drop   = WrEn &  r_full;
    assign w_pop    = (r_state == c_ST_IDLE) & ~r_empty;
    // DoneTx takes priority over the watchdog on the same edge.
    assign w_done   = (r_state == c_ST_WAIT) & DoneTx;
    assign w_expire = (r_state == c_ST_WAIT) & ~DoneTx & (r_timer == c_TMR_LAST);

    always_comb begin
        w_count_nxt = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_nxt = r_count + 1'b1;
            2'b01:   w_count_nxt = r_count - 1'b1;
            default: w_count_nxt = r_count;
        endcase
    end

    // ---------------- State register ----------------
    always_ff @(posedge CLK_Baudin) begin
        if (Rst) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ---------------- Next-state logic ----------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE: if (!r_empty) w_state_nxt = c_ST_LOAD;
            c_ST_LOAD: w_state_nxt = c_ST_WAIT;
            c_ST_WAIT: if (DoneTx || (r_timer == c_TMR_LAST)) w_state_nxt = c_ST_GAP;
            // Hold here while DoneTx is still high so a level-held
            // acknowledge cannot complete the following frame.
            c_ST_GAP:  if (!DoneTx) w_state_nxt = c_ST_IDLE;
            default:   w_state_nxt = c_ST_IDLE;
        endcase
    end

    // ---------------- Output decode ----------------
    always_comb begin
        NewData = (r_state == c_ST_LOAD);
        Busy    = (r_state != c_ST_IDLE);
    end

    // FIFO storage carries no reset; its contents are don't-care.
    always_ff @(posedge CLK_Baudin) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= WrData;
        end
    end

    always_ff @(posedge CLK_Baudin) begin
        if (Rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count <= w_count_nxt;
            r_full  <= (w_count_nxt == c_DEPTH_CNT);
            r_empty <= (w_count_nxt == '0);
        end
    end

    always_ff @(posedge CLK_Baudin) begin
        if (Rst) begin
            r_data_in     <= '0;
            r_timer       <= '0;
            r_overflow    <= 1'b0;
            r_timeout_err <= 1'b0;
            r_sent_count  <= '0;
        end else begin
            // DataIn only changes when a word is popped for issue.
            if (w_pop) r_data_in <= r_mem[r_rd_ptr];

            if (r_state == c_ST_LOAD) begin
                r_timer <= '0;
            end else if (r_state == c_ST_WAIT) begin
                r_timer <= r_timer + c_TMR_W'(1);
            end

            if (w_drop)   r_overflow    <= 1'b1;
            if (w_expire) r_timeout_err <= 1'b1;
            if (w_done)   r_sent_count  <= r_sent_count + 16'd1;
        end
    end

    assign Full       = r_full;
    assign Empty      = r_empty;
    assign Count      = r_count;
    assign DataIn     = r_data_in;
    assign Overflow   = r_overflow;
    assign TimeoutErr = r_timeout_err;
    assign SentCount  = r_sent_count;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_feeder.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_feeder
// Purpose  : Directed self-checking bench for uart_tx_feeder.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx_feeder;

    logic        CLK_Baudin = 1'b0;
    logic        Rst;
    logic [31:0] WrData;
    logic        WrEn;
    logic        Full;
    logic        Empty;
    logic [3:0]  Count;
    logic [31:0] DataIn;
    logic        NewData;
    logic        DoneTx;
    logic        Busy;
    logic        Overflow;
    logic        TimeoutErr;
    logic [15:0] SentCount;

    int n_pass  = 0;
    int n_total = 0;
    int nd_count = 0;

    always #5 CLK_Baudin = ~CLK_Baudin;

    uart_tx_feeder #(
        .DATA_WIDTH(32),
        .DEPTH     (8),
        .ADDR_W    (3),
        .TIMEOUT   (64)
    ) dut (
        .CLK_Baudin(CLK_Baudin),
        .Rst       (Rst),
        .WrData    (WrData),
        .WrEn      (WrEn),
        .Full      (Full),
        .Empty     (Empty),
        .Count     (Count),
        .DataIn    (DataIn),
        .NewData   (NewData),
        .DoneTx    (DoneTx),
        .Busy      (Busy),
        .Overflow  (Overflow),
        .TimeoutErr(TimeoutErr),
        .SentCount (SentCount)
    );

    // Count NewData cycles, sampled mid-cycle.
    always @(negedge CLK_Baudin) begin
        if (NewData === 1'b1) nd_count <= nd_count + 1;
    end

    task automatic tick();
        @(posedge CLK_Baudin);
        #1;
    endtask

    // One-cycle acknowledge; leaves the block in IDLE.
    task automatic ack();
        DoneTx = 1'b1;
        tick();
        DoneTx = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        int pulses;
        Rst = 1'b1; WrEn = 1'b0; WrData = '0; DoneTx = 1'b0;
        tick(); tick();
        Rst = 1'b0;
        n_total++; if (Full !== 1'b0) $display("FAIL rst_full: got %b exp 0", Full); else n_pass++;
        n_total++; if (Empty !== 1'b1) $display("FAIL rst_empty: got %b exp 1", Empty); else n_pass++;
        n_total++; if (Count !== 4'd0) $display("FAIL rst_count: got %0d exp 0", Count); else n_pass++;
        n_total++; if (NewData !== 1'b0) $display("FAIL rst_newdata: got %b exp 0", NewData); else n_pass++;
        n_total++; if (DataIn !== 32'h0) $display("FAIL rst_datain: got %h exp 0", DataIn); else n_pass++;
        n_total++; if (Busy !== 1'b0) $display("FAIL rst_busy: got %b exp 0", Busy); else n_pass++;
        n_total++; if (Overflow !== 1'b0) $display("FAIL rst_ovf: got %b exp 0", Overflow); else n_pass++;
        n_total++; if (TimeoutErr !== 1'b0) $display("FAIL rst_tmo: got %b exp 0", TimeoutErr); else n_pass++;
        n_total++; if (SentCount !== 16'd0) $display("FAIL rst_sent: got %0d exp 0", SentCount); else n_pass++;

        // Reset in the middle of traffic.
        WrEn = 1'b1; WrData = 32'h1111_1111; tick();
        WrData = 32'h2222_2222; tick();
        WrEn = 1'b0; Rst = 1'b1;
        tick(); tick(); tick();
        n_total++; if (Busy !== 1'b0) $display("FAIL rstmid_busy: got %b exp 0", Busy); else n_pass++;
        n_total++; if (Count !== 4'd0) $display("FAIL rstmid_count: got %0d exp 0", Count); else n_pass++;
        n_total++; if (Empty !== 1'b1) $display("FAIL rstmid_empty: got %b exp 1", Empty); else n_pass++;
        n_total++; if (DataIn !== 32'h0) $display("FAIL rstmid_datain: got %h exp 0", DataIn); else n_pass++;
        Rst = 1'b0;
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (NewData === 1'b1) pulses++;
        end
        n_total++; if (pulses !== 0) $display("FAIL rstmid_nopulse: got %0d exp 0", pulses); else n_pass++;
    endtask

    task automatic test_single_word();
        int extra;
        WrEn = 1'b1; WrData = 32'hA5A5_A5A5;
        tick();
        WrEn = 1'b0;
        n_total++; if (Empty !== 1'b0) $display("FAIL single_empty: got %b exp 0", Empty); else n_pass++;
        n_total++; if (NewData !== 1'b0) $display("FAIL single_nd_early: got %b exp 0", NewData); else n_pass++;
        tick();
        n_total++; if (NewData !== 1'b1) $display("FAIL single_nd: got %b exp 1", NewData); else n_pass++;
        n_total++; if (DataIn !== 32'hA5A5_A5A5) $display("FAIL single_datain: got %h exp a5a5a5a5", DataIn); else n_pass++;
        n_total++; if (Count !== 4'd0) $display("FAIL single_count: got %0d exp 0", Count); else n_pass++;
        extra = 0;
        for (int i = 0; i < 34; i++) begin
            tick();
            if (NewData === 1'b1) extra++;
        end
        n_total++; if (extra !== 0) $display("FAIL single_nd_width: got %0d exp 0", extra); else n_pass++;
        DoneTx = 1'b1; tick();
        n_total++; if (SentCount !== 16'd1) $display("FAIL single_sent: got %0d exp 1", SentCount); else n_pass++;
        n_total++; if (Busy !== 1'b1) $display("FAIL single_busy_gap: got %b exp 1", Busy); else n_pass++;
        DoneTx = 1'b0; tick();
        n_total++; if (Busy !== 1'b0) $display("FAIL single_busy_end: got %b exp 0", Busy); else n_pass++;
        n_total++; if (DataIn !== 32'hA5A5_A5A5) $display("FAIL single_hold: got %h exp a5a5a5a5", DataIn); else n_pass++;
    endtask

    task automatic test_ordering();
        logic [31:0] d [3];
        d[0] = 32'hDEAD_BEEF; d[1] = 32'h1234_5678; d[2] = 32'hCAFE_F00D;
        // Occupy the transmitter first so the burst accumulates.
        WrEn = 1'b1; WrData = 32'h0BAD_F00D; tick();
        WrEn = 1'b0; tick(); tick();
        WrEn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            WrData = d[i];
            tick();
            n_total++; if (Count !== 4'(i + 1)) $display("FAIL ord_fill%0d: got %0d exp %0d", i, Count, i + 1); else n_pass++;
        end
        WrEn = 1'b0;
        for (int i = 0; i < 3; i++) begin
            ack();
            tick();
            n_total++; if (NewData !== 1'b1) $display("FAIL ord_nd%0d: got %b exp 1", i, NewData); else n_pass++;
            n_total++; if (DataIn !== d[i]) $display("FAIL ord_data%0d: got %h exp %h", i, DataIn, d[i]); else n_pass++;
            n_total++; if (Count !== 4'(2 - i)) $display("FAIL ord_drain%0d: got %0d exp %0d", i, Count, 2 - i); else n_pass++;
            tick();
        end
        ack();
        n_total++; if (SentCount !== 16'd5) $display("FAIL ord_sent: got %0d exp 5", SentCount); else n_pass++;
    endtask

    task automatic test_overflow();
        int nd_start;
        nd_start = nd_count;
        DoneTx = 1'b0; WrEn = 1'b1;
        for (int i = 0; i < 10; i++) begin
            WrData = 32'hF000_0000 + 32'(i);
            tick();
            if (i == 1) begin
                n_total++; if (DataIn !== 32'hF000_0000) $display("FAIL ovf_first: got %h exp f0000000", DataIn); else n_pass++;
            end
            if (i == 8) begin
                n_total++; if (Full !== 1'b1) $display("FAIL ovf_full: got %b exp 1", Full); else n_pass++;
                n_total++; if (Count !== 4'd8) $display("FAIL ovf_count8: got %0d exp 8", Count); else n_pass++;
                n_total++; if (Overflow !== 1'b0) $display("FAIL ovf_early: got %b exp 0", Overflow); else n_pass++;
            end
            if (i == 9) begin
                n_total++; if (Overflow !== 1'b1) $display("FAIL ovf_flag: got %b exp 1", Overflow); else n_pass++;
                n_total++; if (Count !== 4'd8) $display("FAIL ovf_count_hold: got %0d exp 8", Count); else n_pass++;
            end
        end
        WrEn = 1'b0;
        for (int i = 1; i < 9; i++) begin
            ack();
            tick();
            n_total++; if (DataIn !== (32'hF000_0000 + 32'(i))) $display("FAIL ovf_data%0d: got %h exp %h", i, DataIn, 32'hF000_0000 + 32'(i)); else n_pass++;
            tick();
        end
        ack();
        for (int i = 0; i < 10; i++) tick();
        n_total++; if ((nd_count - nd_start) !== 9) $display("FAIL ovf_issued: got %0d exp 9", nd_count - nd_start); else n_pass++;
        n_total++; if (SentCount !== 16'd14) $display("FAIL ovf_sent: got %0d exp 14", SentCount); else n_pass++;
        n_total++; if (Empty !== 1'b1) $display("FAIL ovf_empty: got %b exp 1", Empty); else n_pass++;
        n_total++; if (Overflow !== 1'b1) $display("FAIL ovf_sticky: got %b exp 1", Overflow); else n_pass++;
    endtask

    task automatic test_timeout();
        DoneTx = 1'b0;
        WrEn = 1'b1; WrData = 32'h7777_0000; tick();
        WrData = 32'h7777_0001; tick();
        WrEn = 1'b0; tick();
        repeat (63) tick();
        n_total++; if (TimeoutErr !== 1'b0) $display("FAIL tmo_early: got %b exp 0", TimeoutErr); else n_pass++;
        n_total++; if (Busy !== 1'b1) $display("FAIL tmo_busy: got %b exp 1", Busy); else n_pass++;
        tick();
        n_total++; if (TimeoutErr !== 1'b1) $display("FAIL tmo_flag: got %b exp 1", TimeoutErr); else n_pass++;
        n_total++; if (SentCount !== 16'd14) $display("FAIL tmo_sent: got %0d exp 14", SentCount); else n_pass++;
        tick(); tick();
        n_total++; if (NewData !== 1'b1) $display("FAIL tmo_next_nd: got %b exp 1", NewData); else n_pass++;
        n_total++; if (DataIn !== 32'h7777_0001) $display("FAIL tmo_next_data: got %h exp 77770001", DataIn); else n_pass++;

        Rst = 1'b1; tick(); Rst = 1'b0;
        n_total++; if (TimeoutErr !== 1'b0) $display("FAIL tmo_rst_clr: got %b exp 0", TimeoutErr); else n_pass++;
        n_total++; if (Overflow !== 1'b0) $display("FAIL ovf_rst_clr: got %b exp 0", Overflow); else n_pass++;

        // DoneTx on the very edge the watchdog would fire.
        WrEn = 1'b1; WrData = 32'h8888_0000; tick();
        WrEn = 1'b0; tick(); tick();
        repeat (63) tick();
        DoneTx = 1'b1; tick();
        n_total++; if (TimeoutErr !== 1'b0) $display("FAIL tmo_tie_flag: got %b exp 0", TimeoutErr); else n_pass++;
        n_total++; if (SentCount !== 16'd1) $display("FAIL tmo_tie_sent: got %0d exp 1", SentCount); else n_pass++;
        DoneTx = 1'b0; tick();
        n_total++; if (Busy !== 1'b0) $display("FAIL tmo_tie_idle: got %b exp 0", Busy); else n_pass++;
    endtask

    task automatic test_level_held();
        int nd0;
        WrEn = 1'b1; WrData = 32'h5555_0000; tick();
        WrData = 32'h5555_0001; tick();
        WrEn = 1'b0; tick();
        nd0 = nd_count;
        DoneTx = 1'b1;
        repeat (5) tick();
        n_total++; if (SentCount !== 16'd2) $display("FAIL lvl_sent_once: got %0d exp 2", SentCount); else n_pass++;
        n_total++; if (nd_count !== nd0) $display("FAIL lvl_no_issue: got %0d exp %0d", nd_count, nd0); else n_pass++;
        n_total++; if (Busy !== 1'b1) $display("FAIL lvl_busy: got %b exp 1", Busy); else n_pass++;
        DoneTx = 1'b0; tick();
        n_total++; if (NewData !== 1'b0) $display("FAIL lvl_idle_nd: got %b exp 0", NewData); else n_pass++;
        tick();
        n_total++; if (NewData !== 1'b1) $display("FAIL lvl_next_nd: got %b exp 1", NewData); else n_pass++;
        n_total++; if (DataIn !== 32'h5555_0001) $display("FAIL lvl_next_data: got %h exp 55550001", DataIn); else n_pass++;
        tick();
        ack();
        n_total++; if (SentCount !== 16'd3) $display("FAIL lvl_sent_final: got %0d exp 3", SentCount); else n_pass++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        test_reset();
        test_single_word();
        test_ordering();
        test_overflow();
        test_timeout();
        test_level_held();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
